// File: rtl/pong_pkg.sv
// pong_pkg: shared playfield, ball and paddle constants plus the ball FSM
// state type for the pong codebase.
package pong_pkg;

    localparam logic [8:0]  PONG_BALL_SIZE        = 9'd4;
    localparam logic [8:0]  PONG_SCREEN_WIDTH     = 9'd320;
    localparam logic [8:0]  PONG_SCREEN_HEIGHT    = 9'd240;
    localparam logic [8:0]  PONG_PADDLE_HEIGHT    = 9'd48;
    localparam logic [8:0]  PONG_LEFT_COLLISION   = 9'd10;
    localparam logic [8:0]  PONG_RIGHT_COLLISION  = 9'd310;
    localparam logic [31:0] PONG_FRAME_RATE_COUNT = 32'd9999999;

    typedef enum logic [1:0] {
        IDLE,
        PUBLISH,
        WAIT_TICK,
        UPDATE
    } ball_state_t;

endpackage

// File: rtl/frame_tick_counter.sv
// frame_tick_counter: free-running 0..FRAME_RATE_COUNT counter that raises
// tick for the single cycle spent at the terminal value.
//   clock - system clock (rising edge)
//   reset - synchronous, active-low
//   tick  - one-cycle movement strobe
module frame_tick_counter
    import pong_pkg::*;
#(
    parameter logic [31:0] FRAME_RATE_COUNT = PONG_FRAME_RATE_COUNT
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    logic [31:0] count;

    always_ff @(posedge clock) begin
        if (!reset) begin
            count <= '0;
        end else if (count == FRAME_RATE_COUNT) begin
            count <= '0;
        end else begin
            count <= count + 32'd1;
        end
    end

    assign tick = (count == FRAME_RATE_COUNT);

endmodule

// File: rtl/ball_processor.sv
// ball_processor: moves the pong ball one pixel per movement tick, bounces it
// off walls and paddles, detects misses and hands each new position to the
// screen drawer through a valid/ready handshake.
//   clock, reset               - system clock, synchronous active-low reset
//   enable                     - game running
//   paddle_left_y/right_y      - paddle top y, sampled only in UPDATE
//   m_ready / m_valid          - position handshake with the drawer
//   ball_x, ball_y             - ball top-left corner
//   left_point, right_point    - one-cycle score pulses
module ball_processor
    import pong_pkg::*;
#(
    parameter logic [8:0]  BALL_SIZE        = PONG_BALL_SIZE,
    parameter logic [8:0]  SCREEN_WIDTH     = PONG_SCREEN_WIDTH,
    parameter logic [8:0]  SCREEN_HEIGHT    = PONG_SCREEN_HEIGHT,
    parameter logic [8:0]  PADDLE_HEIGHT    = PONG_PADDLE_HEIGHT,
    parameter logic [8:0]  LEFT_COLLISION   = PONG_LEFT_COLLISION,
    parameter logic [8:0]  RIGHT_COLLISION  = PONG_RIGHT_COLLISION,
    parameter logic [31:0] FRAME_RATE_COUNT = PONG_FRAME_RATE_COUNT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [8:0] paddle_left_y,
    input  logic [8:0] paddle_right_y,
    input  logic       m_ready,
    output logic       m_valid,
    output logic [8:0] ball_x,
    output logic [8:0] ball_y,
    output logic       left_point,
    output logic       right_point
);

    localparam logic [8:0] CENTRE_X = SCREEN_WIDTH / 9'd2 - BALL_SIZE / 9'd2;
    localparam logic [8:0] CENTRE_Y = SCREEN_HEIGHT / 9'd2 - BALL_SIZE / 9'd2;

    ball_state_t state, next_state;
    logic        tick;
    logic        dx, dy;

    logic [8:0]  upd_x, upd_y;
    logic        upd_dx, upd_dy, upd_lp, upd_rp;
    logic [9:0]  y_bot, x_right, pl_bot, pr_bot;
    logic        left_overlap, right_overlap;

    frame_tick_counter #(
        .FRAME_RATE_COUNT(FRAME_RATE_COUNT)
    ) u_tick (
        .clock(clock),
        .reset(reset),
        .tick (tick)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (enable) next_state = PUBLISH;
            PUBLISH:   if (m_ready) next_state = WAIT_TICK;
            WAIT_TICK: begin
                if (!enable)   next_state = IDLE;
                else if (tick) next_state = UPDATE;
            end
            UPDATE:    next_state = PUBLISH;
            default:   next_state = IDLE;
        endcase
    end

    assign m_valid = (state == PUBLISH);

    // Overlap sums are widened to 10 bits so a paddle near the bottom edge
    // cannot wrap and fake a hit.
    always_comb begin
        y_bot         = {1'b0, ball_y} + {1'b0, BALL_SIZE};
        x_right       = {1'b0, ball_x} + {1'b0, BALL_SIZE};
        pl_bot        = {1'b0, paddle_left_y} + {1'b0, PADDLE_HEIGHT};
        pr_bot        = {1'b0, paddle_right_y} + {1'b0, PADDLE_HEIGHT};
        left_overlap  = (y_bot > {1'b0, paddle_left_y}) && ({1'b0, ball_y} < pl_bot);
        right_overlap = (y_bot > {1'b0, paddle_right_y}) && ({1'b0, ball_y} < pr_bot);

        upd_lp = 1'b0;
        upd_rp = 1'b0;
        upd_dx = dx;
        upd_dy = dy;
        upd_x  = ball_x;

        if (dy && y_bot == {1'b0, SCREEN_HEIGHT}) begin
            upd_dy = 1'b0;
            upd_y  = ball_y - 9'd1;
        end else if (!dy && ball_y == '0) begin
            upd_dy = 1'b1;
            upd_y  = ball_y + 9'd1;
        end else begin
            upd_y  = dy ? ball_y + 9'd1 : ball_y - 9'd1;
        end

        // A miss recentres both axes and overrides the vertical result;
        // dy is left as it was before this update.
        if (!dx && ball_x == LEFT_COLLISION && left_overlap) begin
            upd_dx = 1'b1;
            upd_x  = ball_x + 9'd1;
        end else if (dx && x_right == {1'b0, RIGHT_COLLISION} && right_overlap) begin
            upd_dx = 1'b0;
            upd_x  = ball_x - 9'd1;
        end else if (!dx && ball_x == '0) begin
            upd_rp = 1'b1;
            upd_dx = 1'b0;
            upd_dy = dy;
            upd_x  = CENTRE_X;
            upd_y  = CENTRE_Y;
        end else if (dx && x_right == {1'b0, SCREEN_WIDTH}) begin
            upd_lp = 1'b1;
            upd_dx = 1'b1;
            upd_dy = dy;
            upd_x  = CENTRE_X;
            upd_y  = CENTRE_Y;
        end else begin
            upd_x  = dx ? ball_x + 9'd1 : ball_x - 9'd1;
        end
    end

    // Point pulses are set by UPDATE and cleared every other cycle, so they
    // coincide with the first PUBLISH cycle only.
    always_ff @(posedge clock) begin
        if (!reset) begin
            ball_x      <= CENTRE_X;
            ball_y      <= CENTRE_Y;
            dx          <= 1'b1;
            dy          <= 1'b1;
            left_point  <= 1'b0;
            right_point <= 1'b0;
        end else begin
            left_point  <= 1'b0;
            right_point <= 1'b0;
            case (state)
                IDLE: begin
                    ball_x <= CENTRE_X;
                    ball_y <= CENTRE_Y;
                end
                UPDATE: begin
                    ball_x      <= upd_x;
                    ball_y      <= upd_y;
                    dx          <= upd_dx;
                    dy          <= upd_dy;
                    left_point  <= upd_lp;
                    right_point <= upd_rp;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ball_processor.sv
// tb_ball_processor: randomized scoreboard bench for ball_processor with a
// short movement period. A reference model produces the sequence of published
// positions and point pulses; a monitor compares every publish against it.
module tb_ball_processor;

    logic       clock;
    logic       reset;
    logic       enable;
    logic [8:0] paddle_left_y;
    logic [8:0] paddle_right_y;
    logic       m_ready;
    logic       m_valid;
    logic [8:0] ball_x;
    logic [8:0] ball_y;
    logic       left_point;
    logic       right_point;

    ball_processor #(
        .FRAME_RATE_COUNT(32'd3)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .paddle_left_y (paddle_left_y),
        .paddle_right_y(paddle_right_y),
        .m_ready       (m_ready),
        .m_valid       (m_valid),
        .ball_x        (ball_x),
        .ball_y        (ball_y),
        .left_point    (left_point),
        .right_point   (right_point)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int x;
        int y;
        bit lp;
        bit rp;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    bit   checking = 1'b0;

    // Model state of the ball: position and direction (1 = right / down).
    int mx, my, mdx, mdy;

    function automatic void check(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endfunction

    function automatic bit hits(int by, int py);
        return (by + 4 > py) && (by < py + 48);
    endfunction

    function automatic void model_step(input int pl, input int pr, output bit lp, output bit rp);
        int ny, ndy;
        lp = 1'b0;
        rp = 1'b0;
        ndy = mdy;
        if (mdy == 1 && my + 4 == 240)      begin ndy = 0; ny = my - 1; end
        else if (mdy == 0 && my == 0)       begin ndy = 1; ny = my + 1; end
        else                                ny = (mdy == 1) ? my + 1 : my - 1;

        if (mdx == 0 && mx == 10 && hits(my, pl))              begin mdx = 1; mx = mx + 1; end
        else if (mdx == 1 && mx + 4 == 310 && hits(my, pr))    begin mdx = 0; mx = mx - 1; end
        else if (mdx == 0 && mx == 0)   begin rp = 1'b1; mx = 158; ny = 118; ndy = mdy; end
        else if (mdx == 1 && mx + 4 == 320) begin lp = 1'b1; mx = 158; ny = 118; ndy = mdy; end
        else                            mx = (mdx == 1) ? mx + 1 : mx - 1;
        my  = ny;
        mdy = ndy;
    endfunction

    // Monitor: first cycle of each publish pops the scoreboard; stalled cycles
    // must hold the same position with the point outputs low.
    bit   in_pub = 1'b0;
    exp_t cur;
    always @(negedge clock) begin
        if (!checking || !reset) begin
            in_pub = 1'b0;
        end else if (m_valid) begin
            if (!in_pub) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_underflow", 1, 0);
                    cur = '{x: ball_x, y: ball_y, lp: 1'b0, rp: 1'b0};
                end else begin
                    cur = exp_q.pop_front();
                    check("publish_x", ball_x, cur.x);
                    check("publish_y", ball_y, cur.y);
                    check("left_point", left_point, cur.lp);
                    check("right_point", right_point, cur.rp);
                end
            end else begin
                check("stall_x", ball_x, cur.x);
                check("stall_y", ball_y, cur.y);
                check("stall_points", {left_point, right_point}, 0);
            end
            in_pub = !m_ready;
        end else begin
            in_pub = 1'b0;
            check("idle_points", {left_point, right_point}, 0);
        end
    end

    task automatic run_phase(input int pl, input int pr, input int n, input bit stall_mode);
        bit lp, rp;
        int hold;
        int cyc;
        checking       = 1'b0;
        reset          = 1'b0;
        enable         = 1'b0;
        paddle_left_y  = 9'(pl);
        paddle_right_y = 9'(pr);
        repeat (3) @(posedge clock);
        #1;
        check("reset_m_valid", m_valid, 0);
        check("reset_ball_x", ball_x, 158);
        check("reset_ball_y", ball_y, 118);
        check("reset_points", {left_point, right_point}, 0);

        mx = 158; my = 118; mdx = 1; mdy = 1;
        exp_q.delete();
        exp_q.push_back('{x: 158, y: 118, lp: 1'b0, rp: 1'b0});
        for (int i = 1; i < n; i++) begin
            model_step(pl, pr, lp, rp);
            exp_q.push_back('{x: mx, y: my, lp: lp, rp: rp});
        end

        reset    = 1'b1;
        m_ready  = 1'b1;
        checking = 1'b1;
        repeat (4) begin
            @(posedge clock);
            #1;
            check("disabled_m_valid", m_valid, 0);
        end
        enable = 1'b1;

        hold = 0;
        cyc  = 0;
        while (exp_q.size() > 0 && cyc < n * 60) begin
            @(posedge clock);
            #1;
            cyc++;
            if (stall_mode) begin
                if (hold > 0) begin
                    m_ready = 1'b0;
                    hold--;
                end else if ($urandom_range(0, 99) < 3) begin
                    m_ready = 1'b0;
                    hold    = 19;
                end else begin
                    m_ready = ($urandom_range(0, 3) != 0);
                end
            end
        end
        if (exp_q.size() > 0) begin
            check("phase_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        checking = 1'b0;
        // Leave the DUT stalled in PUBLISH so the next reset must break it out.
        m_ready = 1'b0;
        repeat (8) @(posedge clock);
        #1;
        check("stalled_before_reset", m_valid, 1);
    endtask

    initial begin
        reset          = 1'b0;
        enable         = 1'b0;
        m_ready        = 1'b0;
        paddle_left_y  = '0;
        paddle_right_y = '0;

        run_phase(0, 180, 260, 1'b0);
        run_phase(0, 0, 170, 1'b0);
        for (int p = 0; p < 3; p++) begin
            run_phase(int'($urandom_range(0, 192)), int'($urandom_range(0, 192)), 700, 1'b1);
        end
        run_phase(100, 100, 20, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ball_processor.md
BALL_PROCESSOR -- requirements
Module: ball_processor

Interface
REQ-001 Parameter BALL_SIZE, 9'd4: ball width and height in pixels.
REQ-002 Parameter SCREEN_WIDTH, 9'd320: playfield width in pixels.
REQ-003 Parameter SCREEN_HEIGHT, 9'd240: playfield height in pixels.
REQ-004 Parameter PADDLE_HEIGHT, 9'd48: paddle height in pixels.
REQ-005 Parameter LEFT_COLLISION, 9'd10: x of the left paddle's inner face.
REQ-006 Parameter RIGHT_COLLISION, 9'd310: x of the right paddle's inner face.
REQ-007 Parameter FRAME_RATE_COUNT, 32'd9999999: terminal value of the movement-tick counter.
REQ-008 Port clock, input, 1: system clock; all logic on the rising edge.
REQ-009 Port reset, input, 1: synchronous, active-low reset.
REQ-010 Port enable, input, 1: game running.
REQ-011 Port paddle_left_y, input, 9: top y of the left paddle.
REQ-012 Port paddle_right_y, input, 9: top y of the right paddle.
REQ-013 Port m_ready, input, 1: the downstream screen drawer accepts a position.
REQ-014 Port m_valid, output, 1: ball_x/ball_y hold a new position.
REQ-015 Port ball_x, output, 9: top-left x of the ball.
REQ-016 Port ball_y, output, 9: top-left y of the ball.
REQ-017 Port left_point, output, 1: one-cycle pulse when the left player scores.
REQ-018 Port right_point, output, 1: one-cycle pulse when the right player scores.

Function
REQ-019 The tick counter SHALL count 0..FRAME_RATE_COUNT, wrap to 0, and raise tick for one cycle at the terminal value.
REQ-020 The FSM SHALL have four states: IDLE, PUBLISH, WAIT_TICK, UPDATE.
REQ-021 IDLE: ball SHALL be held at the centre (SCREEN_WIDTH/2-BALL_SIZE/2, SCREEN_HEIGHT/2-BALL_SIZE/2) = (158,118); go to PUBLISH when enable=1.
REQ-022 PUBLISH: m_valid=1 and ball_x/ball_y stable; on m_valid&&m_ready go to WAIT_TICK the next cycle.
REQ-023 WAIT_TICK: enable=0 -> IDLE (recentre); tick=1 -> UPDATE.
REQ-024 A tick that occurs outside WAIT_TICK SHALL be dropped, never queued.
REQ-025 UPDATE (exactly one cycle): apply REQ-026..REQ-031 by priority, then go to PUBLISH.
REQ-026 Vertical: dy=1 and ball_y+BALL_SIZE==SCREEN_HEIGHT -> dy<=0, y-1; dy=0 and ball_y==0 -> dy<=1, y+1; otherwise y±1.
REQ-027 Left paddle hit: dx=0, ball_x==LEFT_COLLISION, ball_y+BALL_SIZE>paddle_left_y and ball_y<paddle_left_y+PADDLE_HEIGHT -> dx<=1, x+1.
REQ-028 Right paddle hit: dx=1, ball_x+BALL_SIZE==RIGHT_COLLISION, with the same overlap test against paddle_right_y -> dx<=0, x-1.
REQ-029 Miss on the left: dx=0 and ball_x==0 -> right_point, ball recentred, dx<=0 (serve toward the conceding player), dy unchanged.
REQ-030 Miss on the right: dx=1 and ball_x+BALL_SIZE==SCREEN_WIDTH -> left_point, ball recentred, dx<=1, dy unchanged.
REQ-031 Otherwise x SHALL change by ±1; a miss takes priority over the vertical rule.
REQ-032 Overlap sums SHALL be computed at 10 bits; no wrap is permitted.
REQ-033 Point pulses SHALL be registered and high only in the first PUBLISH cycle after the scoring UPDATE.
REQ-034 Paddle y inputs SHALL be sampled only in UPDATE.

Reset
REQ-035 On reset=0: state=IDLE, counter=0, ball=(158,118), dx=1, dy=1, m_valid=0, left_point=0, right_point=0.
REQ-036 Reset SHALL override every state, including a PUBLISH stalled by m_ready=0.

Structure
REQ-037 Package pong_pkg SHALL hold the screen/ball/paddle constants and the state enum.
REQ-038 The tick counter SHALL be the sub-module frame_tick_counter (clock, reset, tick).

Verification (FRAME_RATE_COUNT=3)
REQ-039 Reset -> ball=(158,118), m_valid=0, both point outputs 0.
REQ-040 enable=1, m_ready=1 -> first publish is (158,118), the next is (159,119), then one step per 4 cycles.
REQ-041 Free run, paddles at y=0 -> at tick 118, y=236 flips; the next publish has y=235.
REQ-042 paddle_right_y=180 -> at x=306, y=206 the ball bounces; the next publish has x=305, y=205.
REQ-043 paddle_right_y=0 -> the ball passes x=306 and reaches x=316; left_point pulses for exactly 1 cycle; the publish is (158,118) with dx=1.
REQ-044 m_ready=0 for 20 cycles in PUBLISH -> m_valid and the coordinates stay stable; after m_ready=1 the position advances by exactly 1.
